// File: rtl/sdrc_bram_emulator.sv
// Purpose: BRAM-backed responder that mimics the Gowin SDRAM HS controller on its cache-facing I_sdrc_*/O_sdrc_* interface.
// Latency: ack in the cycle after the command edge; read word k is on O_sdrc_data in the cycle ending ReadLatency+k edges after the command.
// Backpressure: none; commands that arrive while busy, or a second one during INIT, are dropped and raise protocol_error.
module sdrc_bram_emulator #(
    parameter int AddressBitWidth     = 12,
    parameter int InitCycles          = 16,
    parameter int ReadLatency         = 4,
    parameter int WriteRecoveryCycles = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        I_sdrc_cmd_en,
    input  logic [2:0]  I_sdrc_cmd,
    input  logic        I_sdrc_precharge_ctrl,
    input  logic        I_sdram_power_down,
    input  logic        I_sdram_selfrefresh,
    input  logic [20:0] I_sdrc_addr,
    input  logic [3:0]  I_sdrc_dqm,
    input  logic [31:0] I_sdrc_data,
    input  logic [7:0]  I_sdrc_data_len,
    output logic [31:0] O_sdrc_data,
    output logic        O_sdrc_init_done,
    output logic        O_sdrc_cmd_ack,
    output logic        protocol_error
);

    localparam int PW    = AddressBitWidth - 8;
    localparam int Depth = 1 << AddressBitWidth;
    localparam int IW    = $clog2(InitCycles + 1);
    localparam int LW    = $clog2(ReadLatency + 1);
    localparam int RW    = $clog2(WriteRecoveryCycles + 2);

    localparam logic [IW-1:0] InitLast = IW'(InitCycles - 1);
    localparam logic [LW-1:0] LatLast  = LW'(ReadLatency - 2);
    localparam logic [RW-1:0] RecLast  = RW'((WriteRecoveryCycles > 0) ? WriteRecoveryCycles - 1 : 0);

    localparam logic [2:0] CmdRefresh   = 3'b001;
    localparam logic [2:0] CmdPrecharge = 3'b010;
    localparam logic [2:0] CmdActivate  = 3'b011;
    localparam logic [2:0] CmdWrite     = 3'b100;
    localparam logic [2:0] CmdRead      = 3'b101;
    localparam logic [2:0] CmdLoadMode  = 3'b111;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_WRITE_BURST,
        ST_READ_WAIT,
        ST_READ_BURST,
        ST_RECOVER
    } state_t;

    logic [31:0]                mem [Depth];
    state_t                     state;
    state_t                     state_nxt;
    state_t                     write_exit;
    logic [IW-1:0]              init_cnt;
    logic [LW-1:0]              lat_cnt;
    logic [RW-1:0]              rec_cnt;
    logic [8:0]                 burst_cnt;
    logic [7:0]                 burst_len;
    logic [7:0]                 col;
    logic [PW-1:0]              burst_page;
    logic [12:0]                open_page;
    logic                       page_vld;
    logic                       init_pend;

    logic                       cmd_single;
    logic                       page_hit;
    logic                       ack_nxt;
    logic                       err_set;
    logic                       latch_cmd;
    logic                       set_page;
    logic                       start_wr;
    logic                       start_rd;
    logic                       mem_we;
    logic                       rd_en;
    logic [AddressBitWidth-1:0] mem_idx;
    logic                       unused_ok;

    // The precharge control bit has no meaning for an always-open BRAM.
    assign unused_ok  = I_sdrc_precharge_ctrl;
    assign cmd_single = (I_sdrc_cmd == CmdRefresh) || (I_sdrc_cmd == CmdPrecharge) ||
                        (I_sdrc_cmd == CmdActivate) || (I_sdrc_cmd == CmdLoadMode);
    assign page_hit   = page_vld && (open_page == I_sdrc_addr[20:8]);
    assign write_exit = (WriteRecoveryCycles > 0) ? ST_RECOVER : ST_IDLE;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus per-edge control strobes for the datapath and BRAM.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        err_set   = I_sdram_power_down || I_sdram_selfrefresh;
        latch_cmd = 1'b0;
        set_page  = 1'b0;
        start_wr  = 1'b0;
        start_rd  = 1'b0;
        mem_we    = 1'b0;
        rd_en     = 1'b0;
        mem_idx   = {burst_page, col};
        case (state)
            ST_INIT: begin
                if (I_sdrc_cmd_en) begin
                    if (cmd_single && !init_pend) begin
                        latch_cmd = 1'b1;
                        set_page  = (I_sdrc_cmd == CmdActivate);
                    end else begin
                        err_set = 1'b1;
                    end
                end
                if (init_cnt == InitLast) begin
                    state_nxt = ST_IDLE;
                    ack_nxt   = init_pend || latch_cmd;
                end
            end
            ST_IDLE: begin
                if (I_sdrc_cmd_en) begin
                    case (I_sdrc_cmd)
                        CmdRefresh, CmdPrecharge, CmdLoadMode: begin
                            ack_nxt = 1'b1;
                        end
                        CmdActivate: begin
                            ack_nxt  = 1'b1;
                            set_page = 1'b1;
                        end
                        CmdWrite: begin
                            // Word 0 arrives with the command itself.
                            ack_nxt   = 1'b1;
                            start_wr  = 1'b1;
                            mem_we    = 1'b1;
                            mem_idx   = I_sdrc_addr[AddressBitWidth-1:0];
                            err_set   = err_set || !page_hit;
                            state_nxt = (I_sdrc_data_len == 8'd0) ? write_exit : ST_WRITE_BURST;
                        end
                        CmdRead: begin
                            ack_nxt   = 1'b1;
                            start_rd  = 1'b1;
                            err_set   = err_set || !page_hit;
                            state_nxt = ST_READ_WAIT;
                        end
                        default: begin
                            err_set = 1'b1;
                        end
                    endcase
                end
            end
            ST_WRITE_BURST: begin
                mem_we = 1'b1;
                if (burst_cnt == {1'b0, burst_len}) begin
                    state_nxt = write_exit;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt == RecLast) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_READ_WAIT: begin
                // Fetch word 0 one edge early so it is registered for its display cycle.
                if (lat_cnt == LatLast) begin
                    rd_en     = 1'b1;
                    state_nxt = ST_READ_BURST;
                end
            end
            ST_READ_BURST: begin
                if (burst_cnt == {1'b0, burst_len}) begin
                    state_nxt = ST_IDLE;
                end else begin
                    rd_en = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
        if (I_sdrc_cmd_en && (state != ST_INIT) && (state != ST_IDLE)) begin
            err_set = 1'b1;
        end
    end

    // Counters, burst bookkeeping, open page and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt         <= '0;
            lat_cnt          <= '0;
            rec_cnt          <= '0;
            burst_cnt        <= '0;
            burst_len        <= '0;
            col              <= '0;
            burst_page       <= '0;
            open_page        <= '0;
            page_vld         <= 1'b0;
            init_pend        <= 1'b0;
            O_sdrc_data      <= '0;
            O_sdrc_init_done <= 1'b0;
            O_sdrc_cmd_ack   <= 1'b0;
            protocol_error   <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (state_nxt == ST_IDLE && state == ST_INIT) begin
                init_pend        <= 1'b0;
                O_sdrc_init_done <= 1'b1;
            end else if (latch_cmd) begin
                init_pend <= 1'b1;
            end
            if (set_page) begin
                open_page <= I_sdrc_addr[20:8];
                page_vld  <= 1'b1;
            end
            rec_cnt <= (state == ST_RECOVER) ? rec_cnt + 1'b1 : '0;
            if (start_wr) begin
                burst_page <= I_sdrc_addr[AddressBitWidth-1:8];
                col        <= I_sdrc_addr[7:0] + 8'd1;
                burst_cnt  <= 9'd1;
                burst_len  <= I_sdrc_data_len;
            end
            if (start_rd) begin
                burst_page <= I_sdrc_addr[AddressBitWidth-1:8];
                col        <= I_sdrc_addr[7:0];
                burst_cnt  <= 9'd0;
                burst_len  <= I_sdrc_data_len;
                lat_cnt    <= '0;
            end
            if (state == ST_READ_WAIT) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (state == ST_WRITE_BURST || rd_en) begin
                col <= col + 8'd1;
            end
            if (state == ST_WRITE_BURST || state == ST_READ_BURST) begin
                burst_cnt <= burst_cnt + 9'd1;
            end
            if (rd_en) begin
                O_sdrc_data <= mem[mem_idx];
            end
            O_sdrc_cmd_ack <= ack_nxt;
            if (err_set) begin
                protocol_error <= 1'b1;
            end
        end
    end

    // Byte-masked BRAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (!I_sdrc_dqm[b]) begin
                    mem[mem_idx][8*b +: 8] <= I_sdrc_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sdrc_bram_emulator.sv
// Purpose: randomized and directed bench for sdrc_bram_emulator against a word-array reference model.
// Latency: expected timing is counted in edges from each command edge.
// Backpressure: commands are issued at the earliest edge the responder must accept them.
module tb_sdrc_bram_emulator;

    localparam int AW   = 12;
    localparam int INIT = 16;
    localparam int RL   = 4;
    localparam int WR   = 2;

    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_LMR = 3'b111;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cmd_en = 1'b0;
    logic [2:0]  cmd    = 3'b000;
    logic        pre    = 1'b0;
    logic        pd     = 1'b0;
    logic        sr     = 1'b0;
    logic [20:0] addr   = '0;
    logic [3:0]  dqm    = '0;
    logic [31:0] wdata  = '0;
    logic [7:0]  dlen   = '0;
    logic [31:0] rdata;
    logic        init_done;
    logic        ack;
    logic        perr;

    sdrc_bram_emulator #(
        .AddressBitWidth    (AW),
        .InitCycles         (INIT),
        .ReadLatency        (RL),
        .WriteRecoveryCycles(WR)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .I_sdrc_cmd_en        (cmd_en),
        .I_sdrc_cmd           (cmd),
        .I_sdrc_precharge_ctrl(pre),
        .I_sdram_power_down   (pd),
        .I_sdram_selfrefresh  (sr),
        .I_sdrc_addr          (addr),
        .I_sdrc_dqm           (dqm),
        .I_sdrc_data          (wdata),
        .I_sdrc_data_len      (dlen),
        .O_sdrc_data          (rdata),
        .O_sdrc_init_done     (init_done),
        .O_sdrc_cmd_ack       (ack),
        .protocol_error       (perr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word array with per-byte "known" flags, open page, sticky error.
    logic [31:0] m_mem   [1 << AW];
    logic [3:0]  m_known [1 << AW];
    logic [12:0] m_page;
    bit          m_pvld;
    bit          m_err;
    logic [31:0] wbuf [256];
    logic [3:0]  mbuf [256];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int midx(input logic [20:0] a, input int k);
        logic [7:0] c;
        c = a[7:0] + 8'(k);
        return int'({a[AW-1:8], c});
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] dm);
        for (int b = 0; b < 4; b++) begin
            if (!dm[b]) begin
                m_mem[idx][8*b +: 8] = d[8*b +: 8];
                m_known[idx][b]      = 1'b1;
            end
        end
    endtask

    task automatic check_word(input string tag, input int idx);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{m_known[idx][b]}};
        if (m != 32'd0) check_eq(tag, rdata & m, m_mem[idx] & m);
    endtask

    task automatic do_reset_init(input bit with_cmd);
        rst_n  = 1'b0;
        cmd_en = 1'b0;
        #1;
        m_err  = 1'b0;
        m_pvld = 1'b0;
        check_eq("rst_data", rdata, 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_perr", 32'(perr), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int e = 1; e <= INIT; e++) begin
            if (with_cmd && e == 1) begin
                cmd_en = 1'b1;
                cmd    = CMD_REF;
                addr   = '0;
            end
            tick();
            cmd_en = 1'b0;
            check_eq("init_done_edge", 32'(init_done), 32'(e == INIT));
            check_eq("init_ack_edge", 32'(ack), 32'(with_cmd && e == INIT));
        end
        tick();
        check_eq("init_ack_once", 32'(ack), 32'd0);
        check_eq("init_done_hold", 32'(init_done), 32'd1);
        check_eq("init_perr", 32'(perr), 32'(m_err));
    endtask

    task automatic do_single(input logic [2:0] c, input logic [20:0] a);
        cmd_en = 1'b1;
        cmd    = c;
        addr   = a;
        tick();
        cmd_en = 1'b0;
        check_eq("single_ack", 32'(ack), 32'd1);
        if (c == CMD_ACT) begin
            m_page = a[20:8];
            m_pvld = 1'b1;
        end
        tick();
        check_eq("single_ack_once", 32'(ack), 32'd0);
    endtask

    task automatic do_write(input logic [20:0] a, input int len, input int rst_at);
        bit perr_exp;
        perr_exp = !(m_pvld && m_page == a[20:8]);
        for (int k = 0; k <= len; k++) begin
            if (k == rst_at) return;
            cmd_en = (k == 0);
            cmd    = CMD_WR;
            addr   = a;
            dlen   = 8'(len);
            wdata  = wbuf[k];
            dqm    = mbuf[k];
            tick();
            m_write(midx(a, k), wbuf[k], mbuf[k]);
            if (k == 0) check_eq("wr_ack", 32'(ack), 32'd1);
            if (k == 1) check_eq("wr_ack_once", 32'(ack), 32'd0);
        end
        cmd_en = 1'b0;
        dqm    = 4'b0000;
        if (perr_exp) m_err = 1'b1;
        for (int r = 0; r < WR; r++) begin
            tick();
            if (len == 0 && r == 0) check_eq("wr_ack_once", 32'(ack), 32'd0);
        end
        check_eq("wr_perr", 32'(perr), 32'(m_err));
    endtask

    task automatic do_read(input logic [20:0] a, input int len, input int inject);
        bit perr_exp;
        int k;
        perr_exp = !(m_pvld && m_page == a[20:8]);
        cmd_en = 1'b1;
        cmd    = CMD_RD;
        addr   = a;
        dlen   = 8'(len);
        tick();
        cmd_en = 1'b0;
        check_eq("rd_ack", 32'(ack), 32'd1);
        for (int e = 1; e <= RL + len; e++) begin
            if (e == inject) begin
                cmd_en = 1'b1;
                cmd    = CMD_ACT;
                addr   = 21'h1FF00;
            end
            tick();
            cmd_en = 1'b0;
            if (e == 1) check_eq("rd_ack_once", 32'(ack), 32'd0);
            if (e == inject) begin
                check_eq("busy_no_ack", 32'(ack), 32'd0);
                perr_exp = 1'b1;
            end
            if (e >= RL - 1) begin
                k = e - (RL - 1);
                if (k > len) k = len;
                check_word("rd_data", midx(a, k));
            end
        end
        if (perr_exp) m_err = 1'b1;
        check_eq("rd_perr", 32'(perr), 32'(m_err));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            m_mem[i]   = '0;
            m_known[i] = '0;
        end
        m_page = '0;
        m_pvld = 1'b0;
        m_err  = 1'b0;
        #1;

        // Init handshake with a refresh latched at edge 1.
        do_reset_init(1'b1);

        // Write/read round trip.
        do_single(CMD_ACT, 21'h000010);
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = 32'h11111111 * k;
            mbuf[k] = 4'b0000;
        end
        do_write(21'h000010, 7, -1);
        do_read(21'h000010, 7, -1);
        check_eq("rt_last_word", rdata, 32'h77777777);

        // Byte mask.
        wbuf[0] = 32'h11223344; mbuf[0] = 4'b0000;
        do_write(21'h000020, 0, -1);
        wbuf[0] = 32'hAABBCCDD; mbuf[0] = 4'b1100;
        do_write(21'h000020, 0, -1);
        do_read(21'h000020, 0, -1);
        check_eq("byte_mask", rdata, 32'h1122CCDD);

        // Column wrap inside the page.
        wbuf[0] = 32'hA0A0A0A0; wbuf[1] = 32'hB1B1B1B1;
        wbuf[2] = 32'hC2C2C2C2; wbuf[3] = 32'hD3D3D3D3;
        for (int k = 0; k < 4; k++) mbuf[k] = 4'b0000;
        do_write(21'h0000FE, 3, -1);
        do_read(21'h0000FE, 1, -1);
        check_eq("wrap_b", rdata, 32'hB1B1B1B1);
        do_read(21'h000000, 1, -1);
        check_eq("wrap_d", rdata, 32'hD3D3D3D3);
        check_eq("wrap_perr", 32'(perr), 32'd0);

        // Randomized traffic within the open page.
        for (int op = 0; op < 40; op++) begin
            int sel;
            int len;
            logic [7:0] c0;
            sel = $urandom_range(0, 4);
            len = $urandom_range(0, 20);
            c0  = 8'($urandom_range(0, 255));
            case (sel)
                0: begin
                    case ($urandom_range(0, 2))
                        0: do_single(CMD_REF, 21'h0);
                        1: do_single(CMD_PRE, 21'h0);
                        default: do_single(CMD_LMR, 21'h0);
                    endcase
                end
                1: do_single(CMD_ACT, {13'($urandom_range(0, 31)), 8'h00});
                2, 3: begin
                    for (int k = 0; k <= len; k++) begin
                        wbuf[k] = $urandom;
                        mbuf[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
                    end
                    do_write({m_page, c0}, len, -1);
                end
                default: do_read({m_page, c0}, len, -1);
            endcase
        end

        // Activate during a read burst is dropped and flagged.
        do_single(CMD_ACT, 21'h000000);
        do_read(21'h000010, 7, 6);
        check_eq("busy_perr", 32'(perr), 32'd1);

        // Mid-burst reset: words 0..2 of the new burst land, 3..7 keep old values.
        for (int k = 0; k < 8; k++) begin
            wbuf[k] = $urandom;
            mbuf[k] = 4'b0000;
        end
        do_write(21'h000040, 7, -1);
        for (int k = 0; k < 8; k++) wbuf[k] = ~wbuf[k];
        do_write(21'h000040, 7, 3);
        do_reset_init(1'b0);
        do_single(CMD_ACT, 21'h000000);
        do_read(21'h000040, 7, -1);

        // Illegal command code in IDLE.
        cmd_en = 1'b1;
        cmd    = 3'b110;
        tick();
        cmd_en = 1'b0;
        check_eq("bad_code_ack", 32'(ack), 32'd0);
        tick();
        m_err = 1'b1;
        check_eq("bad_code_perr", 32'(perr), 32'd1);

        // Page mismatch still returns data but flags the error.
        do_reset_init(1'b0);
        do_single(CMD_ACT, 21'h000100);
        for (int k = 0; k < 4; k++) begin
            wbuf[k] = $urandom;
            mbuf[k] = 4'b0000;
        end
        do_write(21'h000100, 3, -1);
        check_eq("page_ok_perr", 32'(perr), 32'd0);
        do_single(CMD_ACT, 21'h000000);
        do_read(21'h000100, 3, -1);
        check_eq("page_miss_perr", 32'(perr), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
